// File: rtl/fsm_req_scheduler.sv
// fsm_req_scheduler: round-robin arbiter that lends one shared 4-bit
// pattern-matching machine to NREQ requesters, one transaction at a time.
// A transaction ends on the completion code (x==3, y==1) or after TIMEOUT
// wait cycles, and is reported with a single done pulse.
module fsm_req_scheduler #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req,
   input  logic [4*NREQ-1:0] i_req_a,
   input  logic [4*NREQ-1:0] i_req_b,
   output logic [NREQ-1:0]   o_gnt,
   output logic [3:0]        o_fsm_a,
   output logic [3:0]        o_fsm_b,
   input  logic [1:0]        i_fsm_x,
   input  logic              i_fsm_y,
   output logic              o_busy,
   output logic              o_done,
   output logic [2:0]        o_done_id,
   output logic              o_done_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

   state_t            r_state, w_state_nxt;
   logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
   logic [3:0]        r_a, w_a_nxt;
   logic [3:0]        r_b, w_b_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic [2:0]        r_done_id, w_done_id_nxt;
   logic              r_done_err, w_done_err_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [2:0]        r_win, w_win_nxt;
   logic [2:0]        r_last, w_last_nxt;

   logic              w_any;
   logic [2:0]        w_win;
   logic [NREQ-1:0]   w_win_oh;
   logic [3:0]        w_win_a;
   logic [3:0]        w_win_b;
   logic              w_code;
   int                w_dist;
   int                w_best;

   assign w_code = (i_fsm_x == 2'd3) && i_fsm_y;

   // Rotating priority: distance from last+1 (mod NREQ); smallest set wins.
   always_comb begin
      w_any    = 1'b0;
      w_win    = '0;
      w_win_oh = '0;
      w_win_a  = '0;
      w_win_b  = '0;
      w_best   = NREQ;
      w_dist   = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = i - int'(r_last) - 1;
         if (w_dist < 0) w_dist = w_dist + NREQ;
         if (i_req[i] && (w_dist < w_best)) begin
            w_best      = w_dist;
            w_any       = 1'b1;
            w_win       = 3'(i);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
            w_win_a     = i_req_a[4*i +: 4];
            w_win_b     = i_req_b[4*i +: 4];
         end
      end
   end

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
      w_done_id_nxt  = r_done_id;
      w_done_err_nxt = r_done_err;
      w_cnt_nxt      = r_cnt;
      w_win_nxt      = r_win;
      w_last_nxt     = r_last;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_WAIT;
               w_gnt_nxt   = w_win_oh;
               w_a_nxt     = w_win_a;
               w_b_nxt     = w_win_b;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = '0;
               w_win_nxt   = w_win;
            end
         end
         S_WAIT: begin
            // Completion code beats timeout when both happen on one edge.
            if (w_code || (r_cnt == CW'(TIMEOUT - 1))) begin
               w_state_nxt    = S_RELEASE;
               w_gnt_nxt      = '0;
               w_a_nxt        = '0;
               w_b_nxt        = '0;
               w_done_nxt     = 1'b1;
               w_done_id_nxt  = r_win;
               w_done_err_nxt = !w_code;
               w_last_nxt     = r_win;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; pointer resets so requester 0 goes first.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_done_id  <= '0;
         r_done_err <= 1'b0;
         r_cnt      <= '0;
         r_win      <= '0;
         r_last     <= 3'(NREQ - 1);
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_done_id  <= w_done_id_nxt;
         r_done_err <= w_done_err_nxt;
         r_cnt      <= w_cnt_nxt;
         r_win      <= w_win_nxt;
         r_last     <= w_last_nxt;
      end
   end

   assign o_gnt      = r_gnt;
   assign o_fsm_a    = r_a;
   assign o_fsm_b    = r_b;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_done_id  = r_done_id;
   assign o_done_err = r_done_err;

endmodule

// File: tb/tb_fsm_req_scheduler.sv
// Bench for fsm_req_scheduler: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fsm_req_scheduler;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [4*NREQ-1:0] req_a, req_b;
   logic [NREQ-1:0]   gnt;
   logic [3:0]        fsm_a, fsm_b;
   logic [1:0]        fsm_x = 2'd1;
   logic              fsm_y = 1'b0;
   logic              busy, done, done_err;
   logic [2:0]        done_id;

   int n_chk = 0, n_pass = 0;
   int resp_lat = 0;   // 0: code always on, >0: code after N grant cycles, <0: never
   int gcnt = 0;

   fsm_req_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_a(req_a), .i_req_b(req_b),
      .o_gnt(gnt), .o_fsm_a(fsm_a), .o_fsm_b(fsm_b), .i_fsm_x(fsm_x), .i_fsm_y(fsm_y),
      .o_busy(busy), .o_done(done), .o_done_id(done_id), .o_done_err(done_err));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Shared-machine stand-in: raises the completion code after resp_lat grant cycles.
   always @(negedge clk) begin
      if (|gnt) gcnt++; else gcnt = 0;
      if (resp_lat == 0 || (resp_lat > 0 && gcnt >= resp_lat)) begin
         fsm_x = 2'd3; fsm_y = 1'b1;
      end else begin
         fsm_x = 2'd1; fsm_y = 1'b0;
      end
   end

   // Transaction-level model: who owns the machine, since when, and when it was released.
   int cyc = 0, m_owner = -1, m_gcyc = 0, m_ccyc = -100, m_last = NREQ - 1;
   int e_id = 0, e_err = 0, e_gnt, e_a, e_b, e_done, e_busy;
   int m_a = 0, m_b = 0;
   always begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_owner = -1; m_ccyc = -100; m_last = NREQ - 1; e_id = 0; e_err = 0;
      end else if (m_owner >= 0) begin
         if (fsm_x == 2'd3 && fsm_y) begin
            e_id = m_owner; e_err = 0; m_last = m_owner; m_owner = -1; m_ccyc = cyc;
         end else if (cyc - m_gcyc == TIMEOUT) begin
            e_id = m_owner; e_err = 1; m_last = m_owner; m_owner = -1; m_ccyc = cyc;
         end
      end else if (cyc != m_ccyc + 1) begin
         for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (m_owner < 0 && req[idx]) begin
               m_owner = idx; m_gcyc = cyc;
               m_a = int'(req_a[4*idx +: 4]); m_b = int'(req_b[4*idx +: 4]);
            end
         end
      end
      e_gnt  = (m_owner >= 0) ? (1 << m_owner) : 0;
      e_a    = (m_owner >= 0) ? m_a : 0;
      e_b    = (m_owner >= 0) ? m_b : 0;
      e_done = (cyc == m_ccyc) ? 1 : 0;
      e_busy = (m_owner >= 0 || e_done == 1) ? 1 : 0;
      #1;
      chk("model gnt", int'(gnt), e_gnt);
      chk("model fsm_a", int'(fsm_a), e_a);
      chk("model fsm_b", int'(fsm_b), e_b);
      chk("model busy", int'(busy), e_busy);
      chk("model done", int'(done), e_done);
      if (e_done == 1) begin
         chk("model done_id", int'(done_id), e_id);
         chk("model done_err", int'(done_err), e_err);
      end
   end

   task automatic wait_done(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < maxc);
      if (!done) begin
         chk("done wait expired", 0, 1);
         n = -1;
      end
   endtask

   int n, n_hi;
   bit seen;
   int ids[$];
   int rises[$];
   int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
   logic [NREQ-1:0] prev;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = '0; req_a = '0; req_b = '0; resp_lat = 0;
      repeat (2) @(negedge clk);
      chk("reset gnt", int'(gnt), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset fsm_a", int'(fsm_a), 0);
      chk("reset done_id", int'(done_id), 0);
      rst = 1'b0;

      // Single request, code three cycles after grant.
      resp_lat = 3; req_a[3:0] = 4'd10; req_b[3:0] = 4'd9;
      @(negedge clk); req = 4'b0001;
      @(negedge clk);
      chk("t1 gnt", int'(gnt), 1);
      chk("t1 fsm_a", int'(fsm_a), 10);
      chk("t1 fsm_b", int'(fsm_b), 9);
      chk("t1 busy", int'(busy), 1);
      req = '0;
      wait_done(20, n);
      chk("t1 latency", n, 3);
      chk("t1 done_id", int'(done_id), 0);
      chk("t1 done_err", int'(done_err), 0);
      chk("t1 gnt low at done", int'(gnt), 0);
      repeat (3) @(negedge clk);

      // Two simultaneous requesters held.
      resp_lat = 1;
      @(negedge clk); req = 4'b0110;
      @(negedge clk);
      chk("t2 first gnt", int'(gnt), 4'b0010);
      wait_done(20, n);
      chk("t2 first id", int'(done_id), 1);
      wait_done(20, n);
      chk("t2 second id", int'(done_id), 2);
      req = '0;
      repeat (3) @(negedge clk);

      // Fairness from a fresh reset with all four requesting.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; resp_lat = 0; req = 4'b1111; prev = '0;
      for (int i = 0; i < 80 && ids.size() < 6; i++) begin
         @(negedge clk);
         if (|gnt && prev == '0) rises.push_back(i);
         if (done) ids.push_back(int'(done_id));
         prev = gnt;
      end
      req = '0;
      chk("fair done count", ids.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < ids.size()) chk("fair done_id", ids[k], exp_ids[k]);
      for (int k = 1; k < rises.size(); k++)
         chk("fair grant spacing", rises[k] - rises[k-1], 3);
      repeat (3) @(negedge clk);

      // Timeout: code never appears.
      resp_lat = -1;
      @(negedge clk); req = 4'b0001;
      n_hi = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         req = '0;
         if (done) seen = 1'b1;
         else if (|gnt) n_hi++;
      end
      chk("timeout done seen", int'(seen), 1);
      chk("timeout gnt cycles", n_hi, 15);
      chk("timeout done_err", int'(done_err), 1);
      chk("timeout fsm_a", int'(fsm_a), 0);
      chk("timeout fsm_b", int'(fsm_b), 0);
      repeat (3) @(negedge clk);

      // Reset in the 5th grant cycle of requester 2.
      req_a[11:8] = 4'd5; req_b[11:8] = 4'd6;
      @(negedge clk); req = 4'b0100;
      @(negedge clk);
      chk("rst grant to 2", int'(gnt), 4'b0100);
      req = '0;
      repeat (4) @(negedge clk);
      chk("rst fsm_a before", int'(fsm_a), 5);
      rst = 1'b1;
      #1;
      chk("rst async gnt", int'(gnt), 0);
      chk("rst async fsm_a", int'(fsm_a), 0);
      chk("rst async busy", int'(busy), 0);
      chk("rst async done", int'(done), 0);
      @(negedge clk);
      chk("rst no done", int'(done), 0);
      rst = 1'b0; resp_lat = 1; req = 4'b1100;
      @(negedge clk);
      chk("rst regrant to 2", int'(gnt), 4'b0100);
      req = '0;
      wait_done(20, n);
      chk("rst done_id", int'(done_id), 2);
      repeat (3) @(negedge clk);

      // Requester 3 drops req while granted.
      resp_lat = 4;
      @(negedge clk); req = 4'b1000;
      @(negedge clk);
      chk("drop gnt", int'(gnt), 4'b1000);
      @(negedge clk); req = '0;
      wait_done(20, n);
      chk("drop done_id", int'(done_id), 3);
      chk("drop done_err", int'(done_err), 0);
      n_hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (|gnt) n_hi++;
      end
      chk("drop no regrant", n_hi, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fsm_req_scheduler.md
# fsm_req_scheduler

Round-robin scheduler that shares a single 4-bit pattern-matching state machine (operand inputs A/B, outputs x/y) among NREQ requesters. It grants one requester at a time, drives that requester's operand pair into the shared machine, and watches the machine's x/y outputs for the completion code. It then releases the resource and reports pass or timeout per transaction. It sits between the requesting agents and the shared state machine instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 15: maximum WAIT cycles per transaction before abort, ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_a  in  4*NREQ  operand A per requester; requester i uses bits [4i+3:4i].
- req_b  in  4*NREQ  operand B per requester, same packing.
- gnt  out  NREQ  one-hot grant, registered.
- fsm_a  out  4  operand A to the shared machine, registered.
- fsm_b  out  4  operand B to the shared machine, registered.
- fsm_x  in  2  x output of the shared machine.
- fsm_y  in  1  y output of the shared machine.
- busy  out  1  high while a transaction is in flight (gnt or release pending).
- done  out  1  one-cycle completion pulse.
- done_id  out  3  index of the requester that completed; valid with done.
- done_err  out  1  1 = timeout, 0 = completion code seen; valid with done.

## Operation
- Reset, async: gnt=0, fsm_a=0, fsm_b=0, busy=0, done=0, done_id=0, done_err=0, state=IDLE, wait counter=0, last-winner pointer=NREQ-1, so requester 0 has first priority.
- States: IDLE, WAIT, RELEASE.
- IDLE: if any req bit is set at a clock edge:
  - Select the winner as the first set bit searching upward from last+1, modulo NREQ.
  - Register gnt = onehot(winner), fsm_a/fsm_b = the winner's operands, busy=1, counter=0.
  - Go to WAIT.
  - With no req, all outputs hold at their idle values.
- WAIT: operands and grant stay frozen; later changes on req_a/req_b are ignored. Each edge:
  - If fsm_x==2'd3 and fsm_y==1 (completion code): go to RELEASE with err=0.
  - Else if counter==TIMEOUT-1: go to RELEASE with err=1.
  - Else increment the counter.
  - Completion takes priority over timeout on the same edge.
  - The counter width is clog2(TIMEOUT+1) bits and never wraps.
- Entering RELEASE: gnt=0, fsm_a=0, fsm_b=0, done=1, done_id=winner, done_err=err, last=winner.
- RELEASE lasts one cycle. On the next edge, done returns to 0, busy returns to 0, and the state returns to IDLE.
- Requester-side rules:
  - A requester deasserting req while granted does not abort the transaction; it completes or times out normally.
  - A requester still asserting req after its done pulse competes again, but at lowest priority.

## Timing
- req seen high at edge E0 → gnt, fsm_a and fsm_b valid from E0 to E1.
- Completion code sampled at edge En → done high for the single cycle En to En+1. gnt is already low in that cycle.
- Earliest next grant: the edge after RELEASE ends (En+1 sees IDLE; the next gnt appears after En+2). Minimum grant-to-grant spacing is 3 cycles.
- Maximum grant duration is TIMEOUT cycles.
- done, done_id and done_err change only on clock edges; fsm_x/fsm_y feed only registered state.
- Reset asserted in any state clears all outputs immediately, with no done pulse. After reset deasserts, arbitration restarts at requester 0.

## Test plan
- Single request: req=4'b0001, req_a[3:0]=10, req_b[3:0]=9; shared-machine model returns x=3,y=1 three cycles after gnt.
  - Expect gnt=0001 with fsm_a=10, fsm_b=9.
  - Expect done=1, done_id=0, done_err=0 one cycle after the code; gnt low in that cycle.
- Simultaneous req=4'b0110 held: expect grants to requester 1 then requester 2, each followed by its done pulse, with gnt never multi-hot.
- Fairness: req=4'b1111 held continuously, immediate completion code. Expect done_id sequence 0,1,2,3,0,1 with 3-cycle grant spacing.
- Timeout: TIMEOUT=15, model holds x=1,y=0. Expect gnt high for exactly 15 cycles, then done=1, done_err=1, fsm_a=fsm_b=0.
- Reset mid-WAIT: assert rst during the 5th grant cycle of requester 2.
  - Expect gnt, fsm_a and busy to go 0 immediately, with no done pulse.
  - With req=4'b1100 after release, expect the first grant to go to requester 2 (pointer reset to NREQ-1).
- Requester drop: requester 3 deasserts req one cycle after gnt; model returns code later. Expect done_id=3, done_err=0, then no re-grant to 3.
